// File: rtl/idli_sqi_ctrl.sv
// Burst sequencer for the paired SQI memories: LO carries word bits [7:0],
// HI carries bits [15:8]; command/address/dummy phases are mirrored on both.
module idli_sqi_ctrl #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned END_CYCLES = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_vld,
   input  logic              i_req_wr,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              o_req_rdy,
   input  logic              i_stop,
   input  logic              i_wr_vld,
   input  logic [15:0]       i_wr_data,
   output logic              o_wr_rdy,
   output logic              o_rd_vld,
   output logic [15:0]       o_rd_data,
   output logic              o_sqi_cs_n,
   output logic              o_sqi_oe,
   output logic [3:0]        o_sqi_lo,
   output logic [3:0]        o_sqi_hi,
   input  logic [3:0]        i_sqi_lo,
   input  logic [3:0]        i_sqi_hi
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DUMMY,
      S_DATA,
      S_END
   } state_e;

   localparam logic [2:0] END_LOAD = 3'(END_CYCLES - 1);

   state_e            state_q;
   logic [2:0]        cnt_q;
   logic              wr_q;
   logic              stop_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic [7:0]        rnib_q;
   logic [23:0]       addr24;

   assign addr24 = 24'(addr_q);

   function automatic logic [3:0] addr_nib(input logic [23:0] a, input logic [2:0] k);
      case (k)
         3'd0:    return a[23:20];
         3'd1:    return a[19:16];
         3'd2:    return a[15:12];
         3'd3:    return a[11:8];
         3'd4:    return a[7:4];
         3'd5:    return a[3:0];
         default: return 4'h0;
      endcase
   endfunction

   // Write words are handed over only in the cycle before each word's first nibble.
   always_comb begin
      o_wr_rdy = wr_q && i_wr_vld &&
                 (((state_q == S_ADDR) && (cnt_q == 3'd5)) ||
                  ((state_q == S_DATA) && (cnt_q == 3'd1)));
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= S_END;
         cnt_q      <= END_LOAD;
         o_req_rdy  <= 1'b0;
         o_sqi_cs_n <= 1'b1;
         o_sqi_oe   <= 1'b0;
         o_sqi_lo   <= '0;
         o_sqi_hi   <= '0;
         o_rd_vld   <= 1'b0;
         o_rd_data  <= '0;
         wr_q       <= 1'b0;
         stop_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rnib_q     <= '0;
      end else begin
         o_rd_vld <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_req_vld) begin
                  wr_q       <= i_req_wr;
                  addr_q     <= i_req_addr;
                  o_req_rdy  <= 1'b0;
                  o_sqi_cs_n <= 1'b0;
                  o_sqi_oe   <= 1'b1;
                  o_sqi_lo   <= '0;
                  o_sqi_hi   <= '0;
                  cnt_q      <= '0;
                  state_q    <= S_CMD;
               end
            end
            S_CMD: begin
               if (cnt_q == 3'd0) begin
                  cnt_q    <= 3'd1;
                  o_sqi_lo <= wr_q ? 4'h2 : 4'h3;
                  o_sqi_hi <= wr_q ? 4'h2 : 4'h3;
               end else begin
                  cnt_q    <= '0;
                  o_sqi_lo <= addr_nib(addr24, 3'd0);
                  o_sqi_hi <= addr_nib(addr24, 3'd0);
                  state_q  <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (cnt_q != 3'd5) begin
                  cnt_q    <= cnt_q + 3'd1;
                  o_sqi_lo <= addr_nib(addr24, cnt_q + 3'd1);
                  o_sqi_hi <= addr_nib(addr24, cnt_q + 3'd1);
               end else if (!wr_q) begin
                  cnt_q    <= '0;
                  o_sqi_oe <= 1'b0;
                  o_sqi_lo <= '0;
                  o_sqi_hi <= '0;
                  state_q  <= S_DUMMY;
               end else if (i_wr_vld) begin
                  cnt_q    <= '0;
                  wdata_q  <= i_wr_data;
                  o_sqi_lo <= i_wr_data[7:4];
                  o_sqi_hi <= i_wr_data[15:12];
                  state_q  <= S_DATA;
               end else begin
                  cnt_q      <= END_LOAD;
                  o_sqi_cs_n <= 1'b1;
                  o_sqi_oe   <= 1'b0;
                  o_sqi_lo   <= '0;
                  o_sqi_hi   <= '0;
                  state_q    <= S_END;
               end
            end
            S_DUMMY: begin
               if (cnt_q == 3'd0) begin
                  cnt_q <= 3'd1;
               end else begin
                  cnt_q   <= '0;
                  stop_q  <= 1'b0;
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (wr_q) begin
                  if (cnt_q == 3'd0) begin
                     cnt_q    <= 3'd1;
                     o_sqi_lo <= wdata_q[3:0];
                     o_sqi_hi <= wdata_q[11:8];
                  end else if (i_wr_vld) begin
                     cnt_q    <= '0;
                     wdata_q  <= i_wr_data;
                     o_sqi_lo <= i_wr_data[7:4];
                     o_sqi_hi <= i_wr_data[15:12];
                  end else begin
                     cnt_q      <= END_LOAD;
                     o_sqi_cs_n <= 1'b1;
                     o_sqi_oe   <= 1'b0;
                     o_sqi_lo   <= '0;
                     o_sqi_hi   <= '0;
                     state_q    <= S_END;
                  end
               end else if (cnt_q == 3'd0) begin
                  cnt_q  <= 3'd1;
                  rnib_q <= {i_sqi_hi, i_sqi_lo};
                  stop_q <= stop_q | i_stop;
               end else begin
                  // A stop seen anywhere in the word lets it finish, then closes the burst.
                  o_rd_vld  <= 1'b1;
                  o_rd_data <= {rnib_q[7:4], i_sqi_hi, rnib_q[3:0], i_sqi_lo};
                  if (stop_q || i_stop) begin
                     cnt_q      <= END_LOAD;
                     stop_q     <= 1'b0;
                     o_sqi_cs_n <= 1'b1;
                     state_q    <= S_END;
                  end else begin
                     cnt_q <= '0;
                  end
               end
            end
            S_END: begin
               if (cnt_q == 3'd0) begin
                  o_req_rdy <= 1'b1;
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            default: begin
               cnt_q      <= END_LOAD;
               o_sqi_cs_n <= 1'b1;
               o_sqi_oe   <= 1'b0;
               state_q    <= S_END;
            end
         endcase
      end
   end

endmodule
